// File: rtl/stream_width_down.sv
// Stream width down-converter: takes one wide word of Ratio sub-words per input
// handshake and emits them least-significant first, with packet-end marking.
module stream_width_down #(
    parameter int OutBits = 8,
    parameter int Ratio   = 4,
    parameter int CntBits = $clog2(Ratio)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OutBits*Ratio-1:0] in_data,
    input  logic                     in_last,
    input  logic [CntBits-1:0]       in_cnt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OutBits-1:0]       out_data,
    output logic                     out_last
);

    localparam logic [CntBits-1:0] LastIdx = CntBits'(Ratio - 1);

    logic [Ratio-1:0][OutBits-1:0] hold_q;
    logic [CntBits-1:0]            idx_q;
    logic [CntBits-1:0]            fin_q;
    logic                          last_q;

    logic [CntBits-1:0] cnt_eff;
    logic [CntBits-1:0] fin_new;
    logic [CntBits-1:0] next_idx;
    logic               fin_beat;
    logic               in_accept;
    logic               out_accept;

    // A count beyond the last sub-word is only encodable when Ratio is not a
    // power of two; clamp it so the beat index always terminates.
    generate
        if ((1 << CntBits) == Ratio) begin : g_pow2
            assign cnt_eff = in_cnt;
        end else begin : g_clamp
            assign cnt_eff = (in_cnt > LastIdx) ? LastIdx : in_cnt;
        end
    endgenerate

    assign fin_new    = in_last ? cnt_eff : LastIdx;
    assign next_idx   = idx_q + CntBits'(1);
    assign fin_beat   = out_valid && (idx_q == fin_q);
    assign out_accept = out_valid && out_ready;

    // NOTE: in_ready is combinational from out_ready so a new word can load on
    // the same edge the final beat leaves, giving back-to-back words no bubble.
    assign in_ready  = !rst && (!out_valid || (out_ready && fin_beat));
    assign in_accept = in_valid && in_ready;

    // NOTE: the word buffer, final index and last flag carry no reset; they are
    // only consumed while out_valid is set, and out_valid is reset.
    always_ff @(posedge clk) begin
        if (in_accept) begin
            hold_q <= in_data;
            fin_q  <= fin_new;
            last_q <= in_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            idx_q     <= '0;
        end else if (in_accept) begin
            out_valid <= 1'b1;
            idx_q     <= '0;
            out_data  <= in_data[OutBits-1:0];
            out_last  <= in_last && (fin_new == '0);
        end else if (out_accept) begin
            if (fin_beat) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else begin
                idx_q    <= next_idx;
                out_data <= hold_q[next_idx];
                out_last <= last_q && (next_idx == fin_q);
            end
        end
    end

endmodule

// File: tb/tb_stream_width_down.sv
// Directed self-checking bench for stream_width_down (OutBits=8, Ratio=4):
// one task per scenario, inputs driven and outputs sampled mid-cycle.
module tb_stream_width_down;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic [1:0]  in_cnt;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    int n_checks = 0;
    int n_fails  = 0;

    stream_width_down #(.OutBits(8), .Ratio(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_cnt    (in_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    // Inputs are set at the falling edge; this samples the outputs 1ns later
    // (the handshake decision for the next rising edge) and moves one cycle on.
    task automatic step(output logic ov, output logic [7:0] od, output logic ol, output logic ir);
        #1;
        ov = out_valid;
        od = out_data;
        ol = out_last;
        ir = in_ready;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic ov, ol, ir;
        logic [7:0] od;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_cnt = '0; out_ready = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            step(ov, od, ol, ir);
            n_checks++;
            if (ov !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid cyc %0d: got %b want 0", c, ov); end
            n_checks++;
            if (ir !== 1'b0) begin n_fails++; $display("FAIL reset_in_ready cyc %0d: got %b want 0", c, ir); end
            n_checks++;
            if (od !== 8'h00 || ol !== 1'b0) begin n_fails++; $display("FAIL reset_out_data cyc %0d: got %h/%b want 00/0", c, od, ol); end
        end
        rst = 1'b0;
        step(ov, od, ol, ir);
        n_checks++;
        if (ir !== 1'b1) begin n_fails++; $display("FAIL post_reset_in_ready: got %b want 1", ir); end
        n_checks++;
        if (ov !== 1'b0) begin n_fails++; $display("FAIL post_reset_out_valid: got %b want 0", ov); end
    endtask

    task automatic test_single_word();
        logic ov, ol, ir;
        logic [7:0] od;
        logic [7:0] exp_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        in_valid = 1'b1; in_data = 32'h44332211; in_last = 1'b0; in_cnt = 2'd0; out_ready = 1'b1;
        step(ov, od, ol, ir);
        n_checks++;
        if (ir !== 1'b1) begin n_fails++; $display("FAIL single_accept: in_ready got %b want 1", ir); end
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(ov, od, ol, ir);
            n_checks++;
            if (ov !== 1'b1 || od !== exp_b[k] || ol !== 1'b0)
                begin n_fails++; $display("FAIL single_beat %0d: got v=%b d=%h l=%b want v=1 d=%h l=0", k, ov, od, ol, exp_b[k]); end
        end
        step(ov, od, ol, ir);
        n_checks++;
        if (ov !== 1'b0) begin n_fails++; $display("FAIL single_idle: out_valid got %b want 0", ov); end
    endtask

    task automatic test_back_to_back();
        logic ov, ol, ir;
        logic [7:0] od;
        logic [31:0] words [3] = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0};
        logic [31:0] w;
        logic [7:0]  exp_d;
        int wi = 0;
        out_ready = 1'b1; in_last = 1'b0; in_cnt = 2'd0;
        for (int c = 0; c <= 12; c++) begin
            in_valid = (wi < 3);
            in_data  = (wi < 3) ? words[wi] : 32'h0;
            step(ov, od, ol, ir);
            if (c == 0) begin
                n_checks++;
                if (ir !== 1'b1) begin n_fails++; $display("FAIL b2b_first_accept: in_ready got %b want 1", ir); end
            end else begin
                w     = words[(c - 1) / 4];
                exp_d = w[8*((c - 1) % 4) +: 8];
                n_checks++;
                if (ov !== 1'b1 || od !== exp_d || ol !== 1'b0)
                    begin n_fails++; $display("FAIL b2b_beat %0d: got v=%b d=%h l=%b want v=1 d=%h l=0", c - 1, ov, od, ol, exp_d); end
                n_checks++;
                if (ir !== (((c - 1) % 4) == 3))
                    begin n_fails++; $display("FAIL b2b_in_ready beat %0d: got %b want %b", c - 1, ir, ((c - 1) % 4) == 3); end
            end
            if (in_valid && ir) wi++;
        end
        in_valid = 1'b0;
        step(ov, od, ol, ir);
        n_checks++;
        if (ov !== 1'b0) begin n_fails++; $display("FAIL b2b_idle: out_valid got %b want 0", ov); end
    endtask

    task automatic test_short_last();
        logic ov, ol, ir;
        logic [7:0] od;
        logic [7:0] tail [3] = '{8'h85, 8'h86, 8'h87};
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'hDDCCBBAA; in_last = 1'b1; in_cnt = 2'd1;
        step(ov, od, ol, ir);
        in_data = 32'h87868584; in_last = 1'b0; in_cnt = 2'd0;
        step(ov, od, ol, ir);
        n_checks++;
        if (ov !== 1'b1 || od !== 8'hAA || ol !== 1'b0 || ir !== 1'b0)
            begin n_fails++; $display("FAIL short_beat0: got v=%b d=%h l=%b r=%b want v=1 d=aa l=0 r=0", ov, od, ol, ir); end
        step(ov, od, ol, ir);
        n_checks++;
        if (ov !== 1'b1 || od !== 8'hBB || ol !== 1'b1 || ir !== 1'b1)
            begin n_fails++; $display("FAIL short_beat1: got v=%b d=%h l=%b r=%b want v=1 d=bb l=1 r=1", ov, od, ol, ir); end
        in_valid = 1'b0;
        step(ov, od, ol, ir);
        n_checks++;
        if (ov !== 1'b1 || od !== 8'h84 || ol !== 1'b0)
            begin n_fails++; $display("FAIL short_next_word: got v=%b d=%h l=%b want v=1 d=84 l=0", ov, od, ol); end
        for (int k = 0; k < 3; k++) begin
            step(ov, od, ol, ir);
            n_checks++;
            if (ov !== 1'b1 || od !== tail[k])
                begin n_fails++; $display("FAIL short_tail %0d: got v=%b d=%h want v=1 d=%h", k, ov, od, tail[k]); end
        end
        step(ov, od, ol, ir);
        n_checks++;
        if (ov !== 1'b0) begin n_fails++; $display("FAIL short_idle: out_valid got %b want 0", ov); end
    endtask

    task automatic test_backpressure();
        logic ov, ol, ir, prev_stall, prev_l;
        logic [7:0] od, prev_d;
        logic [8:0] exp_q [$];
        logic [8:0] exp_b;
        logic [31:0] word;
        logic lst;
        logic [1:0] cnt;
        int n, sent = 0, beats = 0, exp_total = 0, cyc = 0;
        prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
        word = $urandom; lst = ($urandom_range(0, 3) == 0); cnt = 2'($urandom_range(0, 3));
        while ((sent < 200 || exp_q.size() != 0) && cyc < 20000) begin
            in_valid  = (sent < 200) && ($urandom_range(0, 99) < 70);
            in_data   = word; in_last = lst; in_cnt = cnt;
            out_ready = ($urandom_range(0, 99) < 30);
            step(ov, od, ol, ir);
            cyc++;
            if (prev_stall) begin
                n_checks++;
                if (ov !== 1'b1 || od !== prev_d || ol !== prev_l)
                    begin n_fails++; $display("FAIL bp_stall cyc %0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", cyc, ov, od, ol, prev_d, prev_l); end
            end
            if (ov && out_ready) begin
                beats++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fails++; $display("FAIL bp_extra_beat cyc %0d: got d=%h with nothing expected", cyc, od);
                end else begin
                    exp_b = exp_q.pop_front();
                    if ({ol, od} !== exp_b)
                        begin n_fails++; $display("FAIL bp_beat %0d: got l=%b d=%h want l=%b d=%h", beats, ol, od, exp_b[8], exp_b[7:0]); end
                end
            end
            if (in_valid && ir) begin
                n = lst ? int'(cnt) + 1 : 4;
                for (int k = 0; k < n; k++) exp_q.push_back({lst && (k == n - 1), word[8*k +: 8]});
                exp_total += n;
                sent++;
                word = $urandom; lst = ($urandom_range(0, 3) == 0); cnt = 2'($urandom_range(0, 3));
            end
            prev_stall = ov && !out_ready;
            prev_d = od;
            prev_l = ol;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (cyc >= 20000) begin n_fails++; $display("FAIL bp_timeout: %0d words sent, %0d beats pending", sent, exp_q.size()); end
        n_checks++;
        if (beats != exp_total) begin n_fails++; $display("FAIL bp_beat_count: got %0d want %0d", beats, exp_total); end
        step(ov, od, ol, ir);
        step(ov, od, ol, ir);
        n_checks++;
        if (ov !== 1'b0) begin n_fails++; $display("FAIL bp_idle: out_valid got %b want 0", ov); end
    endtask

    task automatic test_reset_mid_word();
        logic ov, ol, ir;
        logic [7:0] od;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h0D0C0B0A; in_last = 1'b0; in_cnt = 2'd0;
        step(ov, od, ol, ir);
        in_valid = 1'b0;
        step(ov, od, ol, ir);
        step(ov, od, ol, ir);
        n_checks++;
        if (ov !== 1'b1 || od !== 8'h0B) begin n_fails++; $display("FAIL mid_second_beat: got v=%b d=%h want v=1 d=0b", ov, od); end
        rst = 1'b1;
        step(ov, od, ol, ir);
        n_checks++;
        if (ir !== 1'b0) begin n_fails++; $display("FAIL mid_rst_in_ready: got %b want 0", ir); end
        rst = 1'b0;
        step(ov, od, ol, ir);
        n_checks++;
        if (ov !== 1'b0 || ir !== 1'b1) begin n_fails++; $display("FAIL mid_after_rst: got v=%b r=%b want v=0 r=1", ov, ir); end
        in_valid = 1'b1; in_data = 32'h04030201;
        step(ov, od, ol, ir);
        in_valid = 1'b0;
        step(ov, od, ol, ir);
        n_checks++;
        if (ov !== 1'b1 || od !== 8'h01) begin n_fails++; $display("FAIL mid_new_word: got v=%b d=%h want v=1 d=01", ov, od); end
        for (int k = 0; k < 3; k++) step(ov, od, ol, ir);
        n_checks++;
        if (ov !== 1'b1 || od !== 8'h04) begin n_fails++; $display("FAIL mid_new_last_beat: got v=%b d=%h want v=1 d=04", ov, od); end
        step(ov, od, ol, ir);
    endtask

    task automatic test_single_beat_last();
        logic ov, ol, ir;
        logic [7:0] od;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h123456EE; in_last = 1'b1; in_cnt = 2'd0;
        step(ov, od, ol, ir);
        in_valid = 1'b0;
        step(ov, od, ol, ir);
        n_checks++;
        if (ov !== 1'b1 || od !== 8'hEE || ol !== 1'b1)
            begin n_fails++; $display("FAIL one_beat: got v=%b d=%h l=%b want v=1 d=ee l=1", ov, od, ol); end
        n_checks++;
        if (ir !== 1'b1) begin n_fails++; $display("FAIL one_beat_in_ready: got %b want 1", ir); end
        step(ov, od, ol, ir);
        n_checks++;
        if (ov !== 1'b0) begin n_fails++; $display("FAIL one_beat_idle: out_valid got %b want 0", ov); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_short_last();
        test_backpressure();
        test_reset_mid_word();
        test_single_beat_last();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
